// File: rtl/interconn_arb_pkg.sv
// Shared constants and helpers for the MVU interconnect admission/arbitration stage.
package interconn_pkg;

    localparam int N_DEF     = 8;
    localparam int W_DEF     = 64;
    localparam int BADDR_DEF = 15;
    localparam int CNTW_DEF  = 32;

    // Upper bound on source count supported by the mask helper.
    localparam int MAXN  = 32;
    localparam int FLATW = MAXN * MAXN;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W = ptr_w(N_DEF);

    // Extract destination mask idx from a flat array of n-bit masks.
    function automatic logic [MAXN-1:0] mask_slice(input logic [FLATW-1:0] flat,
                                                   input int idx, input int n);
        logic [MAXN-1:0] m;
        m = '0;
        for (int b = 0; b < MAXN; b++) begin
            if (b < n) begin
                m[b] = flat[idx*n + b];
            end else begin
                m[b] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/interconn_arb_if.sv
// Source request and crossbar send buses of the interconnect arbiter.
interface interconn_arb_if #(
    parameter int N     = interconn_pkg::N_DEF,
    parameter int W     = interconn_pkg::W_DEF,
    parameter int BADDR = interconn_pkg::BADDR_DEF,
    parameter int CNTW  = interconn_pkg::CNTW_DEF
) ();
    logic [N-1:0]       src_vld;
    logic [N-1:0]       src_rdy;
    logic [N*N-1:0]     src_to;
    logic [N*BADDR-1:0] src_addr;
    logic [N*W-1:0]     src_word;
    logic [N-1:0]       dest_busy;
    logic [N*N-1:0]     send_to;
    logic [N-1:0]       send_en;
    logic [N*BADDR-1:0] send_addr;
    logic [N*W-1:0]     send_word;
    logic [CNTW-1:0]    conflict_cnt;

    modport slave (
        input  src_vld, src_to, src_addr, src_word, dest_busy,
        output src_rdy, send_to, send_en, send_addr, send_word, conflict_cnt
    );

    modport master (
        output src_vld, src_to, src_addr, src_word, dest_busy,
        input  src_rdy, send_to, send_en, send_addr, send_word, conflict_cnt
    );
endinterface

// File: rtl/interconn_arb_rr_mask_arb.sv
// Round-robin scan granting a set of held entries whose destination masks do not overlap.
module interconn_rr_mask_arb import interconn_pkg::*; #(
    parameter int N = N_DEF,
    localparam int PW = ptr_w(N)
) (
    input  logic [N-1:0]   hv,
    input  logic [N*N-1:0] hto,
    input  logic [N-1:0]   dest_busy,
    input  logic [PW-1:0]  ptr,
    output logic [N-1:0]   gnt,
    output logic [PW-1:0]  ptr_nxt
);
    logic [N-1:0]  claimed;
    logic [N-1:0]  m;
    logic [PW-1:0] s;
    logic          found;

    // Greedy scan from ptr; an entry wins only if none of its destinations are claimed yet.
    always_comb begin
        claimed = dest_busy;
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        s       = '0;
        m       = '0;
        for (int k = 0; k < N; k++) begin
            s = PW'((int'(ptr) + k) % N);
            m = N'(mask_slice(FLATW'(hto), int'(s), N));
            if (hv[s] && ((m & claimed) == '0)) begin
                gnt[s]  = 1'b1;
                claimed = claimed | m;
                if (!found) begin
                    found   = 1'b1;
                    ptr_nxt = PW'((int'(s) + 1) % N);
                end else begin
                    found = 1'b1;
                end
            end else begin
                claimed = claimed;
            end
        end
    end
endmodule

// File: rtl/interconn_arb.sv
// Per-source hold registers, conflict-free grant and zero-filled registered crossbar buses.
module interconn_arb import interconn_pkg::*; #(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int BADDR = BADDR_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic            clk,
    input  logic            clr_n,
    interconn_arb_if.slave  bus
);
    localparam int PW = ptr_w(N);

    logic [N-1:0]       hv_q, hv_d;
    logic [N*N-1:0]     hto_q, hto_d;
    logic [N*BADDR-1:0] haddr_q, haddr_d;
    logic [N*W-1:0]     hword_q, hword_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]       send_en_q, send_en_d;
    logic [N*N-1:0]     send_to_q, send_to_d;
    logic [N*BADDR-1:0] send_addr_q, send_addr_d;
    logic [N*W-1:0]     send_word_q, send_word_d;
    logic [N-1:0]       gnt;
    logic [PW-1:0]      ptr_nxt;
    logic [N-1:0]       rdy;

    interconn_rr_mask_arb #(.N(N)) u_arb (
        .hv        (hv_q),
        .hto       (hto_q),
        .dest_busy (bus.dest_busy),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .ptr_nxt   (ptr_nxt)
    );

    // A slot can take a new entry in the same cycle its current entry leaves.
    assign rdy              = ~hv_q | gnt;
    assign bus.src_rdy      = rdy;
    assign bus.send_en      = send_en_q;
    assign bus.send_to      = send_to_q;
    assign bus.send_addr    = send_addr_q;
    assign bus.send_word    = send_word_q;
    assign bus.conflict_cnt = cnt_q;

    // Admission, send-bus staging and statistics for the next edge.
    always_comb begin
        hv_d        = hv_q;
        hto_d       = hto_q;
        haddr_d     = haddr_q;
        hword_d     = hword_q;
        send_en_d   = gnt;
        send_to_d   = '0;
        send_addr_d = '0;
        send_word_d = '0;
        ptr_d       = ptr_nxt;
        for (int i = 0; i < N; i++) begin
            // Zero-mask requests are handshaken but never occupy the slot.
            if (bus.src_vld[i] && rdy[i] && (bus.src_to[i*N +: N] != '0)) begin
                hv_d[i]                = 1'b1;
                hto_d[i*N +: N]        = bus.src_to[i*N +: N];
                haddr_d[i*BADDR +: BADDR] = bus.src_addr[i*BADDR +: BADDR];
                hword_d[i*W +: W]      = bus.src_word[i*W +: W];
            end else if (gnt[i]) begin
                hv_d[i] = 1'b0;
            end else begin
                hv_d[i] = hv_q[i];
            end
            // Ungranted slices must be zero because the crossbar ORs all sources.
            if (gnt[i]) begin
                send_to_d[i*N +: N]           = hto_q[i*N +: N];
                send_addr_d[i*BADDR +: BADDR] = haddr_q[i*BADDR +: BADDR];
                send_word_d[i*W +: W]         = hword_q[i*W +: W];
            end else begin
                send_to_d[i*N +: N] = '0;
            end
        end
        if ((|(hv_q & ~gnt)) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hv_q        <= '0;
            hto_q       <= '0;
            haddr_q     <= '0;
            hword_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            send_en_q   <= '0;
            send_to_q   <= '0;
            send_addr_q <= '0;
            send_word_q <= '0;
        end else begin
            hv_q        <= hv_d;
            hto_q       <= hto_d;
            haddr_q     <= haddr_d;
            hword_q     <= hword_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            send_en_q   <= send_en_d;
            send_to_q   <= send_to_d;
            send_addr_q <= send_addr_d;
            send_word_q <= send_word_d;
        end
    end
endmodule
